// File: rtl/jump_timing_ctrl.sv
// jump_timing_ctrl: game-mode FSM (IDLE/PLAY/HALT) driven by HID keycodes, plus the jump/gravity cadence counters.
// Latency: outstate, count and sub_count update one Clk after the causing edge; loadplat follows state combinationally.
// Backpressure: none; every input is sampled on every rising edge and all outputs are always valid.
module jump_timing_ctrl #(
  parameter int         CNT_W       = 7,
  parameter int         SUB_W       = 2,
  parameter int         SUB_TAP     = 5,
  parameter logic [7:0] KEY_START   = 8'd44,
  parameter logic [7:0] KEY_HALT    = 8'd41,
  parameter logic [7:0] KEY_RESTART = 8'd21
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic [7:0]       keycode,
  input  logic             cnt_clear,
  input  logic             cnt_enable,
  output logic [2:0]       outstate,
  output logic             loadplat,
  output logic [CNT_W-1:0] count,
  output logic [SUB_W-1:0] sub_count
);

  // Mode codes double as the externally visible outstate value.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    PLAY = 3'b001,
    HALT = 3'b010
  } modeState_t;

  modeState_t modeState;
  modeState_t modeNext;

  // Counter step qualifiers; the sub-counter taps the pre-update primary count.
  logic countStep;
  logic subStep;

  assign countStep = frame_tick && cnt_enable;
  assign subStep   = frame_tick && count[SUB_TAP];

  // Mode register: reset wins, otherwise take the decoded next mode.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      modeState <= IDLE;
    end else begin
      modeState <= modeNext;
    end
  end

  // Next-mode decode: each key only matches the exit of its own mode, so a held key fires once.
  always_comb begin
    modeNext = modeState;
    loadplat = 1'b0;
    case (modeState)
      IDLE: begin
        loadplat = 1'b1;
        if (keycode == KEY_START) begin
          modeNext = PLAY;
        end
      end
      PLAY: begin
        if (keycode == KEY_HALT) begin
          modeNext = HALT;
        end
      end
      HALT: begin
        if (keycode == KEY_RESTART) begin
          modeNext = IDLE;
        end
      end
      default: begin
        modeNext = IDLE;
      end
    endcase
  end

  assign outstate = modeState;

  // Primary jump counter: clear beats enable, advances once per enabled frame, wraps naturally.
  always_ff @(posedge Clk) begin
    if (Reset || cnt_clear) begin
      count <= '0;
    end else if (countStep) begin
      count <= count + CNT_W'(1);
    end
  end

  // Prescaled gravity counter: steps every frame while the tap bit is set, even if count is frozen.
  always_ff @(posedge Clk) begin
    if (Reset || cnt_clear) begin
      sub_count <= '0;
    end else if (subStep) begin
      sub_count <= sub_count + SUB_W'(1);
    end
  end

endmodule

// File: tb/tb_jump_timing_ctrl.sv
// tb_jump_timing_ctrl: table vectors, directed multi-cycle sequences and random stimulus against a reference model.
// Latency: inputs driven at negedge, outputs sampled 1 time unit after the following posedge.
// Backpressure: not applicable; the design has no handshake.
module tb_jump_timing_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       cnt_clear;
  logic       cnt_enable;
  logic [2:0] outstate;
  logic       loadplat;
  logic [6:0] count;
  logic [1:0] sub_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: mode 0=IDLE 1=PLAY 2=HALT, counters as plain integers.
  int mMode = 0;
  int mCnt  = 0;
  int mSub  = 0;

  typedef struct {
    logic       rst;
    logic       tick;
    logic [7:0] key;
    logic       clr;
    logic       en;
    int         expState;
    int         expLoad;
    int         expCount;
    int         expSub;
  } vec_t;

  vec_t vecs[$];

  jump_timing_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .outstate   (outstate),
    .loadplat   (loadplat),
    .count      (count),
    .sub_count  (sub_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int st, input int ld, input int cn, input int sb);
    check({tag, ".outstate"}, int'(outstate), st);
    check({tag, ".loadplat"}, int'(loadplat), ld);
    check({tag, ".count"}, int'(count), cn);
    check({tag, ".sub_count"}, int'(sub_count), sb);
  endtask

  task automatic step(input logic rst, input logic tick, input logic [7:0] key,
                      input logic clr, input logic en);
    @(negedge Clk);
    Reset      = rst;
    frame_tick = tick;
    keycode    = key;
    cnt_clear  = clr;
    cnt_enable = en;
    @(posedge Clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic tick, input logic [7:0] key,
                              input logic clr, input logic en,
                              input int st, input int ld, input int cn, input int sb);
    vec_t v;
    v.rst = rst; v.tick = tick; v.key = key; v.clr = clr; v.en = en;
    v.expState = st; v.expLoad = ld; v.expCount = cn; v.expSub = sb;
    return v;
  endfunction

  // Reference model written from the mode rules and counter arithmetic.
  task automatic modelStep(input logic rst, input logic tick, input logic [7:0] key,
                           input logic clr, input logic en);
    int nextSub;
    if (rst) begin
      mMode = 0; mCnt = 0; mSub = 0;
    end else begin
      if (mMode == 0 && key == 8'd44) mMode = 1;
      else if (mMode == 1 && key == 8'd41) mMode = 2;
      else if (mMode == 2 && key == 8'd21) mMode = 0;
      if (clr) begin
        mCnt = 0; mSub = 0;
      end else begin
        nextSub = (tick && ((mCnt / 32) % 2 == 1)) ? (mSub + 1) % 4 : mSub;
        if (tick && en) mCnt = (mCnt + 1) % 128;
        mSub = nextSub;
      end
    end
  endtask

  initial begin
    logic [7:0] keyPool [9];
    Reset = 1'b1; frame_tick = 1'b0; keycode = 8'd0; cnt_clear = 1'b0; cnt_enable = 1'b0;
    keyPool = '{8'd0, 8'd44, 8'd41, 8'd21, 8'd4, 8'd7, 8'd30, 8'd79, 8'd80};

    // Table: reset, mode walk with ignored keys, basic counter behaviour, reset mid-transition.
    vecs.push_back(mk(1, 0, 8'd0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'd0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd41, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd21, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd44, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd7,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd4,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd30, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd79, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd44, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd21, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd41, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd44, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd41, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd21, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd21, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'd0,  0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0,  0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'd0,  0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'd0,  0, 1, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 8'd0,  1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'd0,  0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'd44, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 8'd41, 0, 1, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].key, vecs[i].clr, vecs[i].en);
      checkAll($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expLoad,
               vecs[i].expCount, vecs[i].expSub);
    end

    // Reset held two cycles, then idle state holds for ten cycles with no key.
    step(1, 0, 8'd0, 0, 0);
    step(1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'd0, 0, 0);
      checkAll($sformatf("idleHold%0d", i), 0, 1, 0, 0);
    end

    // Forty consecutive ticks: sub-counter starts once count has reached 32, wraps at tick 36.
    for (int i = 1; i <= 40; i++) begin
      step(0, 1, 8'd0, 0, 1);
      check($sformatf("run40.count%0d", i), int'(count), i);
      check($sformatf("run40.sub%0d", i), int'(sub_count), (i <= 32) ? 0 : (i - 32) % 4);
    end

    // Tick every fourth cycle, 130 ticks: count holds between ticks and wraps past 127.
    step(0, 0, 8'd0, 1, 0);
    for (int i = 1; i <= 130; i++) begin
      for (int j = 0; j < 3; j++) step(0, 0, 8'd0, 0, 1);
      if (i % 16 == 1) check($sformatf("sparse.hold%0d", i), int'(count), (i - 1) % 128);
      step(0, 1, 8'd0, 0, 1);
    end
    check("sparse.final", int'(count), 2);

    // Count to 50, then clear and enable together on a tick: clear wins.
    step(0, 0, 8'd0, 1, 0);
    for (int i = 0; i < 50; i++) step(0, 1, 8'd0, 0, 1);
    checkAll("at50", 0, 1, 50, 2);
    step(0, 1, 8'd0, 1, 1);
    checkAll("clearWins", 0, 1, 0, 0);

    // In PLAY at count 33: sub-counter keeps stepping with count frozen, then a reset pulse.
    step(0, 0, 8'd44, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    for (int i = 0; i < 33; i++) step(0, 1, 8'd0, 0, 1);
    checkAll("play33", 1, 0, 33, 1);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 8'd0, 0, 0);
      checkAll($sformatf("frozen%0d", i), 1, 0, 33, (1 + i) % 4);
    end
    step(1, 1, 8'd0, 0, 1);
    checkAll("midReset", 0, 1, 0, 0);

    // Random stimulus against the reference model.
    step(1, 0, 8'd0, 0, 0);
    modelStep(1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic       rRst, rTick, rClr, rEn;
      logic [7:0] rKey;
      int         pick;
      rRst  = ($urandom_range(255) == 0);
      rTick = ($urandom_range(1) == 1);
      rClr  = ($urandom_range(127) == 0);
      rEn   = ($urandom_range(3) != 0);
      pick  = $urandom_range(11);
      rKey  = (pick < 9) ? keyPool[pick] : 8'($urandom_range(255));
      step(rRst, rTick, rKey, rClr, rEn);
      modelStep(rRst, rTick, rKey, rClr, rEn);
      checkAll($sformatf("rand%0d", i), mMode, (mMode == 0) ? 1 : 0, mCnt, mSub);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jump_timing_ctrl.md
Name: jump_timing_ctrl

Overview:
- Combines the game-mode state machine (start/play/halt) with the jump-velocity timing counters used by the doodle motion logic.
- The FSM decodes USB HID keycodes into a 3-bit mode code and a platform-load strobe.
- A 7-bit frame counter and a 2-bit prescaled counter provide the gravity-step cadence that the motion block uses to ramp vertical velocity.
- Sits between the keyboard interface and the character/platform motion blocks.

Parameters:
CNT_W, 7, width of the primary jump counter.
SUB_W, 2, width of the prescaled sub-counter.
SUB_TAP, 5, bit index of the primary counter that enables the sub-counter.
KEY_START, 8'd44, keycode (Space) that starts play from IDLE.
KEY_HALT, 8'd41, keycode (Esc) that halts play.
KEY_RESTART, 8'd21, keycode ('R') that returns from HALT to IDLE.

Ports:
Clk  in  1  system clock; all state changes on rising edge.
Reset  in  1  synchronous, active-high reset.
frame_tick  in  1  one-cycle strobe per video frame; counters advance only when high.
keycode  in  8  current USB HID keycode, 0 = no key.
cnt_clear  in  1  synchronous clear of both counters (jump_reset).
cnt_enable  in  1  primary counter enable (jump_enable).
outstate  out  3  mode code: 3'b000 IDLE, 3'b001 PLAY, 3'b010 HALT.
loadplat  out  1  high while in IDLE; platform block loads initial positions.
count  out  CNT_W  primary counter value.
sub_count  out  SUB_W  prescaled counter value.

Behaviour:
- Reset (synchronous, checked first at each Clk edge):
  - state = IDLE, so outstate = 3'b000 and loadplat = 1.
  - count = 0, sub_count = 0.
- FSM is evaluated every Clk edge and is independent of frame_tick:
  - IDLE -> PLAY when keycode == KEY_START; otherwise stay in IDLE.
  - PLAY -> HALT when keycode == KEY_HALT; otherwise stay in PLAY. All other keycodes (movement keys 4, 7, 79, 80 and fire key 30) are ignored by the FSM.
  - HALT -> IDLE when keycode == KEY_RESTART; otherwise stay in HALT.
  - Any unreachable encoding (3'b011..3'b111) -> IDLE on the next edge.
  - Transitions take effect one cycle after the key is sampled. A held key does not cause further transitions, because each key matches only the transition out of its own state.
- outstate is registered: it is the state register value.
- loadplat is combinational: loadplat = (state == IDLE). It is never high in PLAY or HALT.
- Primary counter (count):
  - If Reset or cnt_clear: count <= 0, regardless of frame_tick.
  - Else if frame_tick && cnt_enable: count <= count + 1, wrapping modulo 2^CNT_W (127 -> 0).
  - Else: hold.
- Sub-counter (sub_count):
  - If Reset or cnt_clear: sub_count <= 0.
  - Else if frame_tick && count[SUB_TAP]: sub_count <= sub_count + 1, wrapping (3 -> 0).
  - The enable uses the pre-update count value in the same cycle.
  - The sub-counter does not depend on cnt_enable. If count is frozen with bit 5 set, sub_count keeps incrementing on every frame_tick.
- Simultaneous cnt_clear and cnt_enable: clear wins.
- Counters run in every FSM state; the FSM does not gate them.
- Reset asserted mid-count or mid-transition: all registers return to reset values on that edge.
- No handshake. All outputs are valid one cycle after the causing edge (loadplat follows state combinationally).

Test Plan:
1. Reset held for 2 cycles, then released with keycode = 0 -> outstate = 000, loadplat = 1, count = 0, sub_count = 0; state holds for 10 cycles.
2. keycode = 44 for 1 cycle -> outstate = 001 and loadplat = 0 next cycle. Then keycode = 7, 4, 30 -> stays 001. Then keycode = 41 -> 010. Then keycode = 44 -> stays 010. Then keycode = 21 -> 000 and loadplat = 1.
3. cnt_enable = 1 with frame_tick every cycle for 40 ticks -> count = 40. sub_count = 0 through tick 32; count reaches 32 on tick 32, sub_count then increments on ticks 33-40 and wraps 3 -> 0 at tick 36 -> sub_count = 0 at tick 40.
4. cnt_enable = 1, frame_tick every 4th cycle -> count increments only on tick cycles; 130 ticks -> count = 2 (wrap at 128).
5. count = 50 with cnt_clear = 1 and cnt_enable = 1 on a tick -> count = 0 and sub_count = 0 next cycle; clear has priority.
6. In PLAY with count = 33, Reset pulse for 1 cycle -> outstate = 000, loadplat = 1, count = 0, sub_count = 0 on that edge.
